// File: rtl/mc_controller_v2_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mc_ctrl_pkg
// Description : Shared types and constants for the multi-cycle controller:
//               FSM state encoding, instruction classes, ALU op codes and
//               write-data select encodings.
// Revision    : 2.0 - variable-latency memory, watchdog, HALT/resume
// ============================================================================
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IF   = 4'd0,
    ST_DEC  = 4'd1,
    ST_OPF  = 4'd2,
    ST_MRD  = 4'd3,
    ST_MWR  = 4'd4,
    ST_EXM  = 4'd5,
    ST_EXR  = 4'd6,
    ST_WB   = 4'd7,
    ST_MOV  = 4'd8,
    ST_JMP  = 4'd9,
    ST_LDI  = 4'd10,
    ST_HALT = 4'd11,
    ST_ERR  = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    CL_LDA  = 4'd0,
    CL_STA  = 4'd1,
    CL_ANDA = 4'd2,
    CL_ADDA = 4'd3,
    CL_MOV  = 4'd4,
    CL_ANDR = 4'd5,
    CL_ADDR = 4'd6,
    CL_SUBR = 4'd7,
    CL_JZ   = 4'd8,
    CL_LDI  = 4'd9,
    CL_HLT  = 4'd10
  } class_t;

  localparam logic [1:0] c_ALU_PASS = 2'd0;
  localparam logic [1:0] c_ALU_AND  = 2'd1;
  localparam logic [1:0] c_ALU_ADD  = 2'd2;
  localparam logic [1:0] c_ALU_SUB  = 2'd3;

  localparam logic [1:0] c_WD_ALU = 2'b00;
  localparam logic [1:0] c_WD_MEM = 2'b01;
  localparam logic [1:0] c_WD_MOV = 2'b10;

  // Map the top four opcode bits onto an instruction class.
  function automatic class_t decode_class(input logic [3:0] top);
    class_t cls;
    casez (top)
      4'b000?: cls = CL_LDA;
      4'b001?: cls = CL_STA;
      4'b010?: cls = CL_ANDA;
      4'b011?: cls = CL_ADDA;
      4'b1000: cls = CL_MOV;
      4'b1001: cls = CL_ANDR;
      4'b1010: cls = CL_ADDR;
      4'b1011: cls = CL_SUBR;
      4'b110?: cls = CL_JZ;
      4'b1110: cls = CL_LDI;
      default: cls = CL_HLT;
    endcase
    return cls;
  endfunction

  // States that hold a memory request and wait for mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_IF) || (s == ST_OPF) || (s == ST_MRD) || (s == ST_MWR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_controller_v2_if.sv
`default_nettype none
// ============================================================================
// Interface   : mc_controller_v2_if
// Description : Controller <-> datapath/memory bundle. The master side is the
//               controller; the slave side is the datapath and memory.
// Revision    : 2.0 - variable-latency memory, watchdog, HALT/resume
// ============================================================================
interface mc_controller_v2_if #(
  parameter int OP_W     = 4,
  parameter int ALU_OP_W = 2
);
  logic [OP_W-1:0]     opcode;
  logic                mem_ready;
  logic                resume;

  logic                trld;
  logic                pc_src;
  logic                pc_write;
  logic                iord;
  logic                pc_write_cond;
  logic                mem_write;
  logic                mem_read;
  logic                ir_write;
  logic                ldil;
  logic                reg_src;
  logic                reg_write;
  logic                alu_src_b;
  logic                wr_src;
  logic [1:0]          wd_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic                halted;
  logic                err;

  modport master (
    input  opcode, mem_ready, resume,
    output trld, pc_src, pc_write, iord, pc_write_cond, mem_write, mem_read,
           ir_write, ldil, reg_src, reg_write, alu_src_b, wr_src, wd_src,
           alu_op, halted, err
  );

  modport slave (
    output opcode, mem_ready, resume,
    input  trld, pc_src, pc_write, iord, pc_write_cond, mem_write, mem_read,
           ir_write, ldil, reg_src, reg_write, alu_src_b, wr_src, wd_src,
           alu_op, halted, err
  );
endinterface
`default_nettype wire

// File: rtl/mc_controller_v2_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mc_wait_timer
// Description : Memory-access watchdog counter. Cleared when a memory access
//               starts, incremented on each cycle the access is still waiting.
//               expired flags the last permitted wait cycle.
// Revision    : 2.0 - initial version of the watchdog
// ============================================================================
module mc_wait_timer #(
  parameter int TIMEOUT = 8,
  parameter int TO_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TO_W-1:0] r_cnt;

  // Wait counter: clear has priority; saturates so it never wraps to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam logic [TO_W-1:0] c_LIMIT = TO_W'(TIMEOUT - 1);
      assign expired = (r_cnt == c_LIMIT);
    end else begin : g_no_wdog
      assign expired = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mc_controller_v2.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller_v2
// Description : Multi-cycle control unit for the accumulator/register
//               datapath. Moore FSM with Mealy completion strobes on memory
//               states, memory watchdog with sticky ERR, HALT/resume.
// Revision    : 2.0 - variable-latency memory, watchdog, HALT/resume
// ============================================================================
module mc_controller_v2
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int ALU_OP_W = 2,
  parameter int TIMEOUT  = 8,
  parameter int TO_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mc_controller_v2_if.master     bus
);

  localparam logic [ALU_OP_W-1:0] c_OP_AND = ALU_OP_W'(c_ALU_AND);
  localparam logic [ALU_OP_W-1:0] c_OP_ADD = ALU_OP_W'(c_ALU_ADD);
  localparam logic [ALU_OP_W-1:0] c_OP_SUB = ALU_OP_W'(c_ALU_SUB);

  state_t r_state;
  state_t w_next;
  class_t w_cls;
  logic   w_rdy;
  logic   w_expired;
  logic   w_clr;
  logic   w_inc;

  // Only the top four opcode bits select the class.
  assign w_cls = decode_class(bus.opcode[OP_W-1 -: 4]);

  // A completion during reset must not produce any strobe.
  assign w_rdy = bus.mem_ready & ~rst;

  // Watchdog restarts on entry to a new memory access.
  assign w_clr = is_mem_state(w_next) && (w_next != r_state);
  assign w_inc = is_mem_state(r_state) && !bus.mem_ready;

  mc_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .inc     (w_inc),
    .expired (w_expired)
  );

  // State register; reset lands in instruction fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IF;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode; every output defaults to inactive.
  always_comb begin
    w_next            = r_state;
    bus.trld          = 1'b0;
    bus.pc_src        = 1'b0;
    bus.pc_write      = 1'b0;
    bus.iord          = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_read      = 1'b0;
    bus.ir_write      = 1'b0;
    bus.ldil          = 1'b0;
    bus.reg_src       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_b     = 1'b0;
    bus.wr_src        = 1'b0;
    bus.wd_src        = c_WD_ALU;
    bus.alu_op        = '0;
    bus.halted        = 1'b0;
    bus.err           = 1'b0;

    case (r_state)
      ST_IF: begin
        bus.mem_read = 1'b1;
        if (w_rdy) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          w_next       = ST_DEC;
        end else if (w_expired) begin
          w_next = ST_ERR;
        end
      end

      ST_DEC: begin
        case (w_cls)
          CL_LDA, CL_STA, CL_ANDA, CL_ADDA, CL_JZ: w_next = ST_OPF;
          CL_MOV:                                  w_next = ST_MOV;
          CL_ANDR, CL_ADDR, CL_SUBR:               w_next = ST_EXR;
          CL_LDI:                                  w_next = ST_LDI;
          default:                                 w_next = ST_HALT;
        endcase
      end

      ST_OPF: begin
        bus.mem_read = 1'b1;
        if (w_rdy) begin
          bus.trld     = 1'b1;
          bus.pc_write = 1'b1;
          case (w_cls)
            CL_LDA, CL_ANDA, CL_ADDA: w_next = ST_MRD;
            CL_STA:                   w_next = ST_MWR;
            CL_JZ:                    w_next = ST_JMP;
            default:                  w_next = ST_IF;
          endcase
        end else if (w_expired) begin
          w_next = ST_ERR;
        end
      end

      ST_MRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        bus.reg_src  = 1'b1;
        if ((w_cls == CL_ANDA) || (w_cls == CL_ADDA)) begin
          bus.alu_src_b = 1'b1;
        end
        if (w_rdy) begin
          if (w_cls == CL_LDA) begin
            bus.wd_src    = c_WD_MEM;
            bus.wr_src    = 1'b1;
            bus.reg_write = 1'b1;
            w_next        = ST_IF;
          end else begin
            w_next = ST_EXM;
          end
        end else if (w_expired) begin
          w_next = ST_ERR;
        end
      end

      ST_MWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        bus.reg_src   = 1'b1;
        if (w_rdy) begin
          w_next = ST_IF;
        end else if (w_expired) begin
          w_next = ST_ERR;
        end
      end

      ST_EXM: begin
        bus.alu_src_b = 1'b1;
        bus.alu_op    = (w_cls == CL_ADDA) ? c_OP_ADD : c_OP_AND;
        w_next        = ST_WB;
      end

      ST_EXR: begin
        case (w_cls)
          CL_ANDR: bus.alu_op = c_OP_AND;
          CL_ADDR: bus.alu_op = c_OP_ADD;
          default: bus.alu_op = c_OP_SUB;
        endcase
        w_next = ST_WB;
      end

      ST_WB: begin
        bus.wr_src    = 1'b1;
        bus.wd_src    = c_WD_ALU;
        bus.reg_write = 1'b1;
        w_next        = ST_IF;
      end

      ST_MOV: begin
        bus.wd_src    = c_WD_MOV;
        bus.reg_write = 1'b1;
        w_next        = ST_IF;
      end

      ST_JMP: begin
        bus.pc_src        = 1'b1;
        bus.pc_write_cond = 1'b1;
        w_next            = ST_IF;
      end

      ST_LDI: begin
        bus.ldil = 1'b1;
        w_next   = ST_IF;
      end

      ST_HALT: begin
        bus.halted = 1'b1;
        if (bus.resume) begin
          w_next = ST_IF;
        end
      end

      ST_ERR: begin
        bus.err = 1'b1;
      end

      default: begin
        w_next = ST_IF;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller_v2
// Description : Directed self-checking bench for mc_controller_v2. Each task
//               walks one scenario cycle by cycle against hand-derived
//               control vectors.
// Revision    : 2.0 - covers memory waits, watchdog, HALT/resume, reset abort
// ============================================================================
module tb_mc_controller_v2;

  // Observed control vector bit masks.
  localparam logic [18:0] TRLD   = 19'h40000;
  localparam logic [18:0] PC_SRC = 19'h20000;
  localparam logic [18:0] PC_WR  = 19'h10000;
  localparam logic [18:0] IORD   = 19'h08000;
  localparam logic [18:0] PCWC   = 19'h04000;
  localparam logic [18:0] MEMW   = 19'h02000;
  localparam logic [18:0] MEMR   = 19'h01000;
  localparam logic [18:0] IRW    = 19'h00800;
  localparam logic [18:0] LDIL   = 19'h00400;
  localparam logic [18:0] RSRC   = 19'h00200;
  localparam logic [18:0] RWR    = 19'h00100;
  localparam logic [18:0] ASB    = 19'h00080;
  localparam logic [18:0] WSRC   = 19'h00040;
  localparam logic [18:0] WD_MEM = 19'h00010;
  localparam logic [18:0] WD_MOV = 19'h00020;
  localparam logic [18:0] AL_AND = 19'h00004;
  localparam logic [18:0] AL_ADD = 19'h00008;
  localparam logic [18:0] AL_SUB = 19'h0000C;
  localparam logic [18:0] HLTD   = 19'h00002;
  localparam logic [18:0] ERRB   = 19'h00001;

  typedef struct packed {
    logic [3:0]  op;
    logic        mr;
    logic        rs;
    logic [18:0] ex;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [18:0] obs;

  mc_controller_v2_if #(.OP_W(4), .ALU_OP_W(2)) bus ();

  mc_controller_v2 #(
    .OP_W     (4),
    .ALU_OP_W (2),
    .TIMEOUT  (4),
    .TO_W     (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign obs = {bus.trld, bus.pc_src, bus.pc_write, bus.iord, bus.pc_write_cond,
                bus.mem_write, bus.mem_read, bus.ir_write, bus.ldil, bus.reg_src,
                bus.reg_write, bus.alu_src_b, bus.wr_src, bus.wd_src, bus.alu_op,
                bus.halted, bus.err};

  task automatic drive(input logic mr, input logic rs);
    bus.mem_ready = mr;
    bus.resume    = rs;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    bus.resume    = 1'b0;
    adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.opcode = 4'h0;
    drive(1'b1, 1'b0);
    total++;
    if (obs !== MEMR) begin
      bad++;
      $display("FAIL reset_held got=%h want=%h", obs, MEMR);
    end
    adv();
    drive(1'b1, 1'b1);
    total++;
    if (obs !== MEMR) begin
      bad++;
      $display("FAIL reset_held2 got=%h want=%h", obs, MEMR);
    end
    adv();
    rst = 1'b0;
    drive(1'b0, 1'b0);
    total++;
    if (obs !== MEMR) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", obs, MEMR);
    end
    adv();
  endtask

  task automatic test_lda();
    vec_t v[5];
    apply_reset();
    v = '{'{4'h0, 1'b1, 1'b0, MEMR | IRW | PC_WR},
          '{4'h0, 1'b1, 1'b0, 19'h0},
          '{4'h0, 1'b1, 1'b0, MEMR | TRLD | PC_WR},
          '{4'h0, 1'b1, 1'b0, MEMR | IORD | RSRC | WD_MEM | WSRC | RWR},
          '{4'h0, 1'b0, 1'b0, MEMR}};
    for (int i = 0; i < 5; i++) begin
      bus.opcode = v[i].op;
      drive(v[i].mr, v[i].rs);
      total++;
      if (obs !== v[i].ex) begin
        bad++;
        $display("FAIL lda cyc=%0d got=%h want=%h", i, obs, v[i].ex);
      end
      adv();
    end
  endtask

  task automatic test_sta_wait();
    vec_t v[7];
    apply_reset();
    v = '{'{4'h2, 1'b1, 1'b0, MEMR | IRW | PC_WR},
          '{4'h2, 1'b0, 1'b0, 19'h0},
          '{4'h2, 1'b1, 1'b0, MEMR | TRLD | PC_WR},
          '{4'h2, 1'b0, 1'b0, MEMW | IORD | RSRC},
          '{4'h2, 1'b0, 1'b0, MEMW | IORD | RSRC},
          '{4'h2, 1'b1, 1'b0, MEMW | IORD | RSRC},
          '{4'h2, 1'b0, 1'b0, MEMR}};
    for (int i = 0; i < 7; i++) begin
      bus.opcode = v[i].op;
      drive(v[i].mr, v[i].rs);
      total++;
      if (obs !== v[i].ex) begin
        bad++;
        $display("FAIL sta_wait cyc=%0d got=%h want=%h", i, obs, v[i].ex);
      end
      adv();
    end
  endtask

  task automatic test_anda();
    vec_t v[7];
    apply_reset();
    v = '{'{4'h5, 1'b1, 1'b0, MEMR | IRW | PC_WR},
          '{4'h5, 1'b0, 1'b0, 19'h0},
          '{4'h5, 1'b1, 1'b0, MEMR | TRLD | PC_WR},
          '{4'h5, 1'b1, 1'b0, MEMR | IORD | RSRC | ASB},
          '{4'h5, 1'b1, 1'b0, ASB | AL_AND},
          '{4'h5, 1'b0, 1'b0, WSRC | RWR},
          '{4'h5, 1'b0, 1'b0, MEMR}};
    for (int i = 0; i < 7; i++) begin
      bus.opcode = v[i].op;
      drive(v[i].mr, v[i].rs);
      total++;
      if (obs !== v[i].ex) begin
        bad++;
        $display("FAIL anda cyc=%0d got=%h want=%h", i, obs, v[i].ex);
      end
      adv();
    end
  endtask

  task automatic test_addr_subr();
    vec_t v[9];
    apply_reset();
    v = '{'{4'hA, 1'b1, 1'b0, MEMR | IRW | PC_WR},
          '{4'hA, 1'b1, 1'b0, 19'h0},
          '{4'hA, 1'b0, 1'b0, AL_ADD},
          '{4'hA, 1'b1, 1'b0, WSRC | RWR},
          '{4'hB, 1'b1, 1'b0, MEMR | IRW | PC_WR},
          '{4'hB, 1'b0, 1'b0, 19'h0},
          '{4'hB, 1'b0, 1'b0, AL_SUB},
          '{4'hB, 1'b0, 1'b0, WSRC | RWR},
          '{4'hB, 1'b0, 1'b0, MEMR}};
    for (int i = 0; i < 9; i++) begin
      bus.opcode = v[i].op;
      drive(v[i].mr, v[i].rs);
      total++;
      if (obs !== v[i].ex) begin
        bad++;
        $display("FAIL addr_subr cyc=%0d got=%h want=%h", i, obs, v[i].ex);
      end
      adv();
    end
  endtask

  task automatic test_mov_ldi();
    vec_t v[7];
    apply_reset();
    v = '{'{4'h8, 1'b1, 1'b0, MEMR | IRW | PC_WR},
          '{4'h8, 1'b0, 1'b0, 19'h0},
          '{4'h8, 1'b0, 1'b0, WD_MOV | RWR},
          '{4'hE, 1'b1, 1'b0, MEMR | IRW | PC_WR},
          '{4'hE, 1'b0, 1'b0, 19'h0},
          '{4'hE, 1'b1, 1'b0, LDIL},
          '{4'hE, 1'b0, 1'b0, MEMR}};
    for (int i = 0; i < 7; i++) begin
      bus.opcode = v[i].op;
      drive(v[i].mr, v[i].rs);
      total++;
      if (obs !== v[i].ex) begin
        bad++;
        $display("FAIL mov_ldi cyc=%0d got=%h want=%h", i, obs, v[i].ex);
      end
      adv();
    end
  endtask

  task automatic test_jz();
    vec_t v[6];
    apply_reset();
    v = '{'{4'hC, 1'b1, 1'b0, MEMR | IRW | PC_WR},
          '{4'hC, 1'b0, 1'b0, 19'h0},
          '{4'hC, 1'b0, 1'b0, MEMR},
          '{4'hC, 1'b1, 1'b0, MEMR | TRLD | PC_WR},
          '{4'hC, 1'b1, 1'b0, PC_SRC | PCWC},
          '{4'hC, 1'b0, 1'b0, MEMR}};
    for (int i = 0; i < 6; i++) begin
      bus.opcode = v[i].op;
      drive(v[i].mr, v[i].rs);
      total++;
      if (obs !== v[i].ex) begin
        bad++;
        $display("FAIL jz cyc=%0d got=%h want=%h", i, obs, v[i].ex);
      end
      adv();
    end
  endtask

  task automatic test_ready_wins();
    vec_t v[7];
    apply_reset();
    v = '{'{4'h8, 1'b0, 1'b0, MEMR},
          '{4'h8, 1'b0, 1'b0, MEMR},
          '{4'h8, 1'b0, 1'b0, MEMR},
          '{4'h8, 1'b1, 1'b0, MEMR | IRW | PC_WR},
          '{4'h8, 1'b0, 1'b0, 19'h0},
          '{4'h8, 1'b0, 1'b0, WD_MOV | RWR},
          '{4'h8, 1'b0, 1'b0, MEMR}};
    for (int i = 0; i < 7; i++) begin
      bus.opcode = v[i].op;
      drive(v[i].mr, v[i].rs);
      total++;
      if (obs !== v[i].ex) begin
        bad++;
        $display("FAIL ready_wins cyc=%0d got=%h want=%h", i, obs, v[i].ex);
      end
      adv();
    end
  endtask

  task automatic test_halt();
    vec_t v[16];
    apply_reset();
    v[0] = '{4'hF, 1'b1, 1'b0, MEMR | IRW | PC_WR};
    v[1] = '{4'hF, 1'b0, 1'b0, 19'h0};
    for (int i = 2; i < 10; i++) v[i] = '{4'hF, 1'b0, 1'b0, HLTD};
    v[10] = '{4'hF, 1'b0, 1'b1, HLTD};
    v[11] = '{4'hF, 1'b0, 1'b0, MEMR};
    v[12] = '{4'hF, 1'b1, 1'b1, MEMR | IRW | PC_WR};
    v[13] = '{4'hF, 1'b0, 1'b1, 19'h0};
    v[14] = '{4'hF, 1'b0, 1'b1, HLTD};
    v[15] = '{4'hF, 1'b0, 1'b1, MEMR};
    for (int i = 0; i < 16; i++) begin
      bus.opcode = v[i].op;
      drive(v[i].mr, v[i].rs);
      total++;
      if (obs !== v[i].ex) begin
        bad++;
        $display("FAIL halt cyc=%0d got=%h want=%h", i, obs, v[i].ex);
      end
      adv();
    end
  endtask

  task automatic test_reset_mid_jz();
    vec_t v[3];
    apply_reset();
    v = '{'{4'hC, 1'b1, 1'b0, MEMR | IRW | PC_WR},
          '{4'hC, 1'b0, 1'b0, 19'h0},
          '{4'hC, 1'b0, 1'b0, MEMR}};
    for (int i = 0; i < 3; i++) begin
      bus.opcode = v[i].op;
      drive(v[i].mr, v[i].rs);
      total++;
      if (obs !== v[i].ex) begin
        bad++;
        $display("FAIL rst_jz cyc=%0d got=%h want=%h", i, obs, v[i].ex);
      end
      adv();
    end
    rst = 1'b1;
    drive(1'b1, 1'b0);
    total++;
    if (obs !== MEMR) begin
      bad++;
      $display("FAIL rst_jz_abort got=%h want=%h", obs, MEMR);
    end
    adv();
    rst = 1'b0;
    drive(1'b0, 1'b0);
    total++;
    if (obs !== MEMR) begin
      bad++;
      $display("FAIL rst_jz_if got=%h want=%h", obs, MEMR);
    end
    adv();
    drive(1'b1, 1'b0);
    total++;
    if (obs !== (MEMR | IRW | PC_WR)) begin
      bad++;
      $display("FAIL rst_jz_fetch got=%h want=%h", obs, MEMR | IRW | PC_WR);
    end
    adv();
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.opcode = 4'h0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0);
      total++;
      if (obs !== MEMR) begin
        bad++;
        $display("FAIL timeout_wait cyc=%0d got=%h want=%h", i, obs, MEMR);
      end
      adv();
    end
    for (int i = 0; i < 24; i++) begin
      drive(1'(i & 1), 1'b1);
      total++;
      if (obs !== ERRB) begin
        bad++;
        $display("FAIL timeout_err cyc=%0d got=%h want=%h", i, obs, ERRB);
      end
      adv();
    end
    rst = 1'b1;
    drive(1'b0, 1'b0);
    total++;
    if (obs !== MEMR) begin
      bad++;
      $display("FAIL timeout_rst got=%h want=%h", obs, MEMR);
    end
    adv();
    rst = 1'b0;
    drive(1'b1, 1'b0);
    total++;
    if (obs !== (MEMR | IRW | PC_WR)) begin
      bad++;
      $display("FAIL timeout_refetch got=%h want=%h", obs, MEMR | IRW | PC_WR);
    end
    adv();
  endtask

  initial begin
    bus.opcode    = 4'h0;
    bus.mem_ready = 1'b0;
    bus.resume    = 1'b0;
    test_reset();
    test_lda();
    test_sta_wait();
    test_anda();
    test_addr_subr();
    test_mov_ldi();
    test_jz();
    test_ready_wins();
    test_halt();
    test_reset_mid_jz();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_controller_v2.md
# mc_controller_v2

Parametrised multi-cycle control unit for the accumulator/register datapath used by the FIR filter sequencer. It is a Moore FSM with Mealy completion strobes and drives the PC, IR, memory, register file and ALU control lines. Compared with the previous controller it adds a variable-latency memory handshake (`mem_ready`), a memory-timeout watchdog with a sticky error state, a HALT/resume instruction, and parametrised opcode and ALU-op widths.

## Interface
- `OP_W`, 4, opcode width (≥4); class decoded from `opcode[OP_W-1:OP_W-4]`, lower bits ignored
- `ALU_OP_W`, 2, ALU op width (≥2); codes zero-extended
- `TIMEOUT`, 8, max wait cycles per memory access; 0 disables watchdog
- `TO_W`, 4, watchdog counter width; must satisfy 2^TO_W > TIMEOUT

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock
- `rst`, in, 1: reset, asynchronous, active-high
- `opcode`, in, `OP_W`: from IR, stable from DEC onward
- `mem_ready`, in, 1: memory completes current access this cycle
- `resume`, in, 1: leave HALT
- `trld`, `pc_src`, `pc_write`, `iord`, `pc_write_cond`, `mem_write`, `mem_read`, `ir_write`, `ldil`, `reg_src`, `reg_write`, `alu_src_b`, `wr_src`, out, 1 each: datapath controls
- `wd_src`, out, 2: write-data select (00 ALU, 01 memory, 10 register move)
- `alu_op`, out, `ALU_OP_W`: 0 PASS, 1 AND, 2 ADD, 3 SUB
- `halted`, out, 1: in HALT
- `err`, out, 1: in ERR (sticky)

## Operation
- Outputs default to 0 in every state. Only the signals listed per state are asserted.
- Memory states (IF, OPF, MRD, MWR) hold their request continuously. Completion strobes are asserted only in the cycle `mem_ready`=1, and the transition happens on that edge.
  - IF: `mem_read`, `iord`=0. On ready: `ir_write`, `pc_write` (`pc_src`=0), then go to DEC.
  - OPF: `mem_read`, `iord`=0. On ready: `trld`, `pc_write`, then go to the class state.
  - MRD: `mem_read`, `iord`, `reg_src`. For LDA, on ready: `wd_src`=01, `wr_src`, `reg_write`, then go to IF. For ANDA/ADDA: `alu_src_b`; on ready go to EXM.
  - MWR: `mem_write`, `iord`, `reg_src`. On ready go to IF.
- DEC (1 cycle): two-word classes go to OPF; all others go directly to their state.
- Class map, from the top 4 opcode bits:
  - 000x LDA: OPF → MRD
  - 001x STA: OPF → MWR
  - 010x ANDA: OPF → MRD → EXM(`alu_src_b`, AND) → WB
  - 011x ADDA: OPF → MRD → EXM(`alu_src_b`, ADD) → WB
  - 1000 MOV: MOV(`wd_src`=10, `reg_write`) → IF
  - 1001 / 1010 / 1011 ANDR / ADDR / SUBR: EXR(`alu_src_b`=0, AND/ADD/SUB) → WB
  - 110x JZ: OPF → JMP(`pc_src`, `pc_write_cond`) → IF
  - 1110 LDI: LDI(`ldil`) → IF
  - 1111 HLT: HALT
- WB: `wr_src`, `wd_src`=00, `reg_write`, then go to IF.
- HALT: `halted`=1. Stays until `resume`=1, then goes to IF.
- Watchdog: the counter clears on entry to any memory state and increments each cycle without `mem_ready`.
  - If `TIMEOUT`>0 and the count reaches `TIMEOUT`-1 with `mem_ready`=0, the next state is ERR.
  - ERR: `err`=1, all strobes 0. ERR is left only by `rst`.

## Timing
- Reset (async): state goes to IF and the counter to 0. While reset is held and immediately after, `mem_read`=1 and all other outputs are 0.
- Zero-wait instruction latencies (cycles, IF to next IF):
  - LDA 4, STA 4, ANDA/ADDA 6
  - MOV 3, ANDR/ADDR/SUBR 4, JZ 4, LDI 3
- Each wait cycle adds 1 cycle to the access. Strobes never repeat within one access.
- `mem_ready` outside a memory state is ignored.
- `mem_ready` and the timeout condition in the same cycle: ready wins.
- `resume` held high while entering HALT: HALT lasts exactly 1 cycle.
- `rst` during any state, including ERR or a pending access, aborts immediately with no completion strobe.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state enum (IF, DEC, OPF, MRD, MWR, EXM, EXR, WB, MOV, JMP, LDI, HALT, ERR)
  - class codes
  - ALU op constants
  - `wd_src` encodings
- Sub-module `mc_wait_timer` (`TIMEOUT`, `TO_W`) holds the clear/increment counter and outputs `expired`.

## Test plan
- LDA (opcode 0000), zero-wait: `ir_write` in cycle 0, `trld` in cycle 2, `reg_write` with `wd_src`=01 in cycle 3, back to IF in cycle 4.
- STA with `mem_ready` delayed 2 cycles in MWR: `mem_write` is high for 3 cycles and deasserts after the ready cycle; total 6 cycles.
- ADDR (1010) then SUBR (1011): EXR shows `alu_op`=2 and then 3, with `alu_src_b`=0; `reg_write` in the WB cycle only.
- `TIMEOUT`=4, `mem_ready` never asserted in IF: `err`=1 after 4 cycles and stays 1 for 20+ cycles; `rst` returns to IF.
- HLT (1111): `halted`=1 until `resume` pulses on cycle 10, then IF on the next cycle. A second HLT with `resume` tied high shows `halted` for 1 cycle.
- `rst` asserted mid-OPF of JZ (1100): no `pc_write_cond`, state is IF, `trld`=0.
